// File: rtl/mouse_joy_emu_if.sv
// Signal bundle between hps_io-side sources, the mouse/joystick emulator and the BBC core joystick inputs.
// The master side drives mouse packets and real-stick state; the slave side returns the emulated stick.
interface mouse_joy_emu_if;
   logic [24:0]       ps2_mouse;
   logic signed [7:0] joy_x;
   logic signed [7:0] joy_y;
   logic              joy_fire;
   logic              joy_active;
   logic              mouse_off;
   logic [11:0]       out_x;
   logic [11:0]       out_y;
   logic              out_fire_n;
   logic              mouse_sel;

   modport master (
      output ps2_mouse, joy_x, joy_y, joy_fire, joy_active, mouse_off,
      input  out_x, out_y, out_fire_n, mouse_sel
   );

   modport slave (
      input  ps2_mouse, joy_x, joy_y, joy_fire, joy_active, mouse_off,
      output out_x, out_y, out_fire_n, mouse_sel
   );
endinterface

// File: rtl/mouse_joy_emu.sv
// PS/2 mouse to analog joystick emulator: integrates clamped mouse deltas into a saturating
// signed position per axis, muxes against the real stick and optionally drifts back to centre.
module mouse_joy_emu #(
   parameter int MAX_STEP       = 10,
   parameter int RECENTRE_TICKS = 0,
   parameter int DECAY_DIV      = 65536
) (
   input logic            clk_sys,
   input logic            reset,
   mouse_joy_emu_if.slave emu_if
);

   localparam bit DRIFT_EN = (RECENTRE_TICKS != 0);
   localparam int IDLE_W   = (RECENTRE_TICKS > 1) ? $clog2(RECENTRE_TICKS) : 1;
   localparam int DIV_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
   localparam logic [IDLE_W-1:0] IDLE_LAST =
      IDLE_W'((RECENTRE_TICKS > 0) ? RECENTRE_TICKS - 1 : 0);
   localparam logic [DIV_W-1:0] DIV_LAST =
      DIV_W'((DECAY_DIV > 0) ? DECAY_DIV - 1 : 0);
   localparam logic signed [8:0] STEP_MAX = 9'(MAX_STEP);

   typedef enum logic {IDLE_WAIT, DRIFT} state_t;

   function automatic logic signed [8:0] clamp_step(input logic signed [8:0] d);
      if (d > STEP_MAX)       return STEP_MAX;
      else if (d < -STEP_MAX) return -STEP_MAX;
      else                    return d;
   endfunction

   function automatic logic signed [7:0] sat8(input logic signed [9:0] s);
      if (s > 10'sd127)       return 8'sh7f;
      else if (s < -10'sd128) return 8'sh80;
      else                    return s[7:0];
   endfunction

   function automatic logic signed [7:0] toward_zero(input logic signed [7:0] p);
      if (p > 8'sd0)          return p - 8'sd1;
      else if (p < 8'sd0)     return p + 8'sd1;
      else                    return p;
   endfunction

   logic                old_stb_q;
   logic                evt;
   logic                clear;
   logic signed [7:0]   pos_x_q, pos_x_d;
   logic signed [7:0]   pos_y_q, pos_y_d;
   logic                mouse_sel_q, mouse_sel_d;
   logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
   logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
   state_t              state_q, state_d;
   logic                drift_step;
   logic signed [8:0]   dx_c, dy_c;
   logic signed [9:0]   nx, ny;
   logic                unused_mouse_bits;

   assign evt   = emu_if.ps2_mouse[24] ^ old_stb_q;
   assign clear = emu_if.joy_active | emu_if.mouse_off;

   assign dx_c = clamp_step({emu_if.ps2_mouse[4], emu_if.ps2_mouse[15:8]});
   assign dy_c = clamp_step({emu_if.ps2_mouse[5], emu_if.ps2_mouse[23:16]});

   // Ten-bit sums cannot overflow, so saturation sees the true result.
   assign nx = {{2{pos_x_q[7]}}, pos_x_q} + {dx_c[8], dx_c};
   assign ny = {{2{pos_y_q[7]}}, pos_y_q} - {dy_c[8], dy_c};

   assign unused_mouse_bits = ^{emu_if.ps2_mouse[7:6], emu_if.ps2_mouse[3:2]};

   always_ff @(posedge clk_sys) begin
      if (reset) state_q <= IDLE_WAIT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!DRIFT_EN || clear || evt) begin
         state_d = IDLE_WAIT;
      end else begin
         case (state_q)
            IDLE_WAIT: if (mouse_sel_q && idle_cnt_q == IDLE_LAST) state_d = DRIFT;
            DRIFT:     state_d = DRIFT;
            default:   state_d = IDLE_WAIT;
         endcase
      end
   end

   always_comb begin
      drift_step = 1'b0;
      idle_cnt_d = idle_cnt_q;
      div_cnt_d  = div_cnt_q;
      if (!DRIFT_EN || clear || evt) begin
         idle_cnt_d = '0;
         div_cnt_d  = '0;
      end else begin
         case (state_q)
            IDLE_WAIT: begin
               div_cnt_d = '0;
               if (mouse_sel_q) begin
                  if (idle_cnt_q == IDLE_LAST) idle_cnt_d = '0;
                  else                         idle_cnt_d = idle_cnt_q + 1'b1;
               end
            end
            DRIFT: begin
               if (div_cnt_q == DIV_LAST) begin
                  div_cnt_d  = '0;
                  drift_step = 1'b1;
               end else begin
                  div_cnt_d  = div_cnt_q + 1'b1;
               end
            end
            default: begin
               idle_cnt_d = '0;
               div_cnt_d  = '0;
            end
         endcase
      end
   end

   // A clear in the same cycle as a strobe toggle swallows that packet.
   always_comb begin
      pos_x_d     = pos_x_q;
      pos_y_d     = pos_y_q;
      mouse_sel_d = mouse_sel_q;
      if (clear) begin
         pos_x_d     = '0;
         pos_y_d     = '0;
         mouse_sel_d = 1'b0;
      end else if (evt) begin
         pos_x_d     = sat8(nx);
         pos_y_d     = sat8(ny);
         mouse_sel_d = 1'b1;
      end else if (drift_step) begin
         pos_x_d     = toward_zero(pos_x_q);
         pos_y_d     = toward_zero(pos_y_q);
      end
   end

   always_ff @(posedge clk_sys) begin
      old_stb_q <= emu_if.ps2_mouse[24];
      if (reset) begin
         pos_x_q     <= '0;
         pos_y_q     <= '0;
         mouse_sel_q <= 1'b0;
         idle_cnt_q  <= '0;
         div_cnt_q   <= '0;
      end else begin
         pos_x_q     <= pos_x_d;
         pos_y_q     <= pos_y_d;
         mouse_sel_q <= mouse_sel_d;
         idle_cnt_q  <= idle_cnt_d;
         div_cnt_q   <= div_cnt_d;
      end
   end

   assign emu_if.out_x = mouse_sel_q ? {~pos_x_q[7], pos_x_q[6:0], 4'b0000}
                                     : {~emu_if.joy_x[7], emu_if.joy_x[6:0], 4'b0000};
   assign emu_if.out_y = mouse_sel_q ? {~pos_y_q[7], pos_y_q[6:0], 4'b0000}
                                     : {~emu_if.joy_y[7], emu_if.joy_y[6:0], 4'b0000};
   assign emu_if.out_fire_n = mouse_sel_q ? ~|emu_if.ps2_mouse[1:0] : ~emu_if.joy_fire;
   assign emu_if.mouse_sel  = mouse_sel_q;

endmodule

// File: tb/tb_mouse_joy_emu.sv
// Directed bench for mouse_joy_emu: a vector table for single-packet behaviour plus
// hand-written sequences for saturation, recentre drift and reset during drift.
module tb_mouse_joy_emu;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, rst1;
   mouse_joy_emu_if if0 ();
   mouse_joy_emu_if if1 ();

   mouse_joy_emu dut0 (
      .clk_sys (clk),
      .reset   (rst0),
      .emu_if  (if0)
   );

   mouse_joy_emu #(
      .MAX_STEP       (10),
      .RECENTRE_TICKS (16),
      .DECAY_DIV      (4)
   ) dut1 (
      .clk_sys (clk),
      .reset   (rst1),
      .emu_if  (if1)
   );

   typedef struct {
      bit                tog;
      logic signed [8:0] dx;
      logic signed [8:0] dy;
      logic [1:0]        btn;
      logic [7:0]        jx;
      logic [7:0]        jy;
      bit                jf;
      bit                ja;
      bit                mo;
      logic [11:0]       ex;
      logic [11:0]       ey;
      bit                efn;
      bit                esel;
   } vec_t;

   vec_t vecs [10];
   int   total  = 0;
   int   passed = 0;
   logic stb0   = 1'b0;
   logic stb1   = 1'b0;

   function automatic logic [24:0] pkt(input logic s, input logic signed [8:0] dx,
                                       input logic signed [8:0] dy, input logic [1:0] btn);
      return {s, dy[7:0], dx[7:0], 2'b00, dy[8], dx[8], 2'b00, btn};
   endfunction

   function automatic logic [11:0] enc(input logic signed [7:0] p);
      return {~p[7], p[6:0], 4'b0000};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%03h, expected 0x%03h", name, act, exp);
   endtask

   task automatic send0(input logic signed [8:0] dx, input logic signed [8:0] dy);
      stb0 = ~stb0;
      if0.ps2_mouse = pkt(stb0, dx, dy, 2'b00);
   endtask

   task automatic send1(input logic signed [8:0] dx, input logic signed [8:0] dy);
      stb1 = ~stb1;
      if1.ps2_mouse = pkt(stb1, dx, dy, 2'b00);
   endtask

   initial begin
      int p;

      vecs[0] = '{tog:0, dx:9'sd0,    dy:9'sd0,  btn:2'b00, jx:8'h12, jy:8'hF0, jf:1, ja:0, mo:0,
                  ex:12'h920, ey:12'h700, efn:0, esel:0};
      vecs[1] = '{tog:1, dx:9'sd5,    dy:9'sd3,  btn:2'b00, jx:8'h12, jy:8'hF0, jf:1, ja:0, mo:0,
                  ex:12'h850, ey:12'h7D0, efn:1, esel:1};
      vecs[2] = '{tog:0, dx:9'sd5,    dy:9'sd3,  btn:2'b01, jx:8'h12, jy:8'hF0, jf:1, ja:0, mo:0,
                  ex:12'h850, ey:12'h7D0, efn:0, esel:1};
      vecs[3] = '{tog:1, dx:9'sd100,  dy:9'sd0,  btn:2'b01, jx:8'h12, jy:8'hF0, jf:1, ja:0, mo:0,
                  ex:12'h8F0, ey:12'h7D0, efn:0, esel:1};
      vecs[4] = '{tog:1, dx:-9'sd100, dy:-9'sd4, btn:2'b00, jx:8'h12, jy:8'hF0, jf:1, ja:0, mo:0,
                  ex:12'h850, ey:12'h810, efn:1, esel:1};
      vecs[5] = '{tog:0, dx:9'sd0,    dy:9'sd0,  btn:2'b00, jx:8'h12, jy:8'hF0, jf:1, ja:0, mo:1,
                  ex:12'h920, ey:12'h700, efn:0, esel:0};
      vecs[6] = '{tog:1, dx:9'sd2,    dy:9'sd0,  btn:2'b00, jx:8'h12, jy:8'hF0, jf:1, ja:0, mo:0,
                  ex:12'h820, ey:12'h800, efn:1, esel:1};
      vecs[7] = '{tog:1, dx:9'sd7,    dy:9'sd0,  btn:2'b00, jx:8'h12, jy:8'hF0, jf:1, ja:1, mo:0,
                  ex:12'h920, ey:12'h700, efn:0, esel:0};
      vecs[8] = '{tog:0, dx:9'sd7,    dy:9'sd0,  btn:2'b00, jx:8'h12, jy:8'hF0, jf:1, ja:0, mo:0,
                  ex:12'h920, ey:12'h700, efn:0, esel:0};
      vecs[9] = '{tog:1, dx:9'sd0,    dy:9'sd0,  btn:2'b00, jx:8'h12, jy:8'hF0, jf:1, ja:0, mo:0,
                  ex:12'h800, ey:12'h800, efn:1, esel:1};

      rst0 = 1'b1;
      rst1 = 1'b1;
      if0.ps2_mouse  = pkt(stb0, 9'sd0, 9'sd0, 2'b00);
      if0.joy_x      = 8'h12;
      if0.joy_y      = 8'hF0;
      if0.joy_fire   = 1'b1;
      if0.joy_active = 1'b0;
      if0.mouse_off  = 1'b0;
      if1.ps2_mouse  = pkt(stb1, 9'sd0, 9'sd0, 2'b00);
      if1.joy_x      = 8'h00;
      if1.joy_y      = 8'h00;
      if1.joy_fire   = 1'b0;
      if1.joy_active = 1'b0;
      if1.mouse_off  = 1'b0;
      step();
      step();
      rst0 = 1'b0;

      for (int i = 0; i < 10; i++) begin
         if (vecs[i].tog) stb0 = ~stb0;
         if0.ps2_mouse  = pkt(stb0, vecs[i].dx, vecs[i].dy, vecs[i].btn);
         if0.joy_x      = vecs[i].jx;
         if0.joy_y      = vecs[i].jy;
         if0.joy_fire   = vecs[i].jf;
         if0.joy_active = vecs[i].ja;
         if0.mouse_off  = vecs[i].mo;
         step();
         chk($sformatf("v%0d_out_x", i), if0.out_x, vecs[i].ex);
         chk($sformatf("v%0d_out_y", i), if0.out_y, vecs[i].ey);
         chk($sformatf("v%0d_fire_n", i), {11'b0, if0.out_fire_n}, {11'b0, vecs[i].efn});
         chk($sformatf("v%0d_sel", i), {11'b0, if0.mouse_sel}, {11'b0, vecs[i].esel});
      end

      // Positive saturation from centre: steps of 10 up to 127, never wrapping.
      for (int k = 1; k <= 20; k++) begin
         send0(9'sd100, 9'sd0);
         step();
         p = (10 * k > 127) ? 127 : 10 * k;
         chk($sformatf("sat_pos_k%0d", k), if0.out_x, enc(8'(p)));
      end
      chk("sat_pos_final", if0.out_x, 12'hFF0);

      if0.mouse_off = 1'b1;
      step();
      chk("mouse_off_sel", {11'b0, if0.mouse_sel}, 12'h000);
      if0.mouse_off = 1'b0;

      for (int k = 1; k <= 20; k++) begin
         send0(-9'sd100, 9'sd0);
         step();
         p = (-10 * k < -128) ? -128 : -10 * k;
         chk($sformatf("sat_neg_k%0d", k), if0.out_x, enc(8'(p)));
      end
      chk("sat_neg_final", if0.out_x, 12'h000);
      chk("sat_neg_y", if0.out_y, 12'h800);

      // Recentre drift on the second instance.
      rst1 = 1'b0;
      step();
      chk("drift_rst_sel", {11'b0, if1.mouse_sel}, 12'h000);
      chk("drift_rst_x", if1.out_x, 12'h800);
      send1(9'sd3, 9'sd0);
      step();
      chk("drift_start_sel", {11'b0, if1.mouse_sel}, 12'h001);
      chk("drift_start_x", if1.out_x, 12'h830);
      for (int k = 1; k <= 32; k++) begin
         if1.ps2_mouse = pkt(stb1, 9'sd0, 9'sd0, 2'b00);
         step();
         p = (k < 20) ? 3 : (k < 24) ? 2 : (k < 28) ? 1 : 0;
         chk($sformatf("drift_k%0d", k), if1.out_x, enc(8'(p)));
      end
      chk("drift_end_sel", {11'b0, if1.mouse_sel}, 12'h001);
      chk("drift_end_y", if1.out_y, 12'h800);

      // Reset in the middle of drift, with a strobe toggle on the same edge.
      for (int i = 0; i < 5; i++) begin
         send1(9'sd10, 9'sd0);
         step();
      end
      chk("pre_drift_x", if1.out_x, 12'hB20);
      repeat (18) step();
      chk("pre_reset_hold_x", if1.out_x, 12'hB20);
      rst1 = 1'b1;
      send1(9'sd10, 9'sd0);
      step();
      chk("mid_reset_sel", {11'b0, if1.mouse_sel}, 12'h000);
      chk("mid_reset_x", if1.out_x, 12'h800);
      rst1 = 1'b0;
      step();
      chk("post_reset_sel1", {11'b0, if1.mouse_sel}, 12'h000);
      step();
      chk("post_reset_sel2", {11'b0, if1.mouse_sel}, 12'h000);
      send1(9'sd0, 9'sd0);
      step();
      chk("post_reset_evt_sel", {11'b0, if1.mouse_sel}, 12'h001);
      chk("post_reset_evt_x", if1.out_x, 12'h800);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
